tile_fb_arbiter: RTL and testbench

//  Owns the single-port 768x8 tile RAM (32x24 tiles of 20x20 px) behind the 640x480 VGA scan-out.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/tile_fb_arbiter_if.sv | 18 +
 rtl/tile_wr_fifo.sv | 64 ++++++
 rtl/tile_fb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tile_fb_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the tile frame-buffer arbiter.
// Covers the VGA visible area, the tile grid geometry, the colour type and
// palette constants, the arbiter state enum and the writer request record.
package vga_pkg;

  localparam logic [9:0] HPIXELS = 10'd640;
  localparam logic [9:0] VPIXELS = 10'd480;

  localparam int TILE_PX = 20;
  localparam int TILES_X = 32;
  localparam int TILES_Y = 24;

  localparam logic [9:0] NUM_TILES = 10'd768;
  localparam logic [9:0] LAST_TILE = NUM_TILES - 10'd1;

  typedef logic [7:0] colour_t;

  localparam colour_t BLK = 8'h00;
  localparam colour_t WHT = 8'hFF;
  localparam colour_t RED = 8'hE0;
  localparam colour_t BLU = 8'h03;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // One queued writer update: tile index plus colour.
  typedef struct packed {
    logic [9:0] addr;
    colour_t    data;
  } wr_req_t;

endpackage

// File: rtl/tile_fb_arbiter_if.sv
// Writer-side handshake bundle of the tile frame-buffer arbiter.
//   wr_valid : request valid (writer -> arbiter)
//   wr_ready : arbiter can accept a request (arbiter -> writer)
//   wr_addr  : tile index
//   wr_data  : RRRGGGBB colour
// master = game-logic writer, slave = arbiter.
interface tile_fb_arbiter_if;
  import vga_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [9:0] wr_addr;
  colour_t    wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/tile_wr_fifo.sv
// Synchronous FIFO holding pending writer requests.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push       : enqueue push_data; ignored while full
//   push_data  : request to enqueue
//   pop        : dequeue the head; ignored while empty
//   head       : oldest request (valid when !empty)
//   full/empty : occupancy flags, from registered pointers only
module tile_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  wr_req_t     mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  // full is the pre-pop value, so a push while full is refused even if a pop
  // happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= {(AW+1){1'b0}};
      rptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/tile_fb_arbiter.sv
// Arbiter owning the single-port 768x8 tile RAM behind 640x480 VGA scan-out.
// Display reads win every active cycle; during blanking at most one write is
// issued, a running clear sweep first, otherwise the head of the writer FIFO.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   hc, vc         : scan counters (visible while hc<640 && vc<480)
//   wr             : writer handshake (slave side)
//   clr_req        : one-cycle pulse starting a full-screen clear
//   clr_color      : fill colour, sampled with clr_req
//   clr_busy       : clear sweep in progress
//   wr_err         : sticky, an out-of-range request was dropped
//   ram_addr/we/wdata : RAM port, combinational from state and hc/vc
//   ram_rdata      : RAM read data, one cycle after the address
//   px_color       : registered pixel colour, two cycles after hc/vc
module tile_fb_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_PX    = vga_pkg::TILE_PX,
  parameter int TILES_X    = vga_pkg::TILES_X
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  tile_fb_arbiter_if.slave  wr,
  input  logic              clr_req,
  input  colour_t           clr_color,
  output logic              clr_busy,
  output logic              wr_err,
  output logic [9:0]        ram_addr,
  output logic              ram_we,
  output colour_t           ram_wdata,
  input  colour_t           ram_rdata,
  output colour_t           px_color
);

  arb_state_t state;
  arb_state_t next_state;

  logic       active;
  logic       active_d1;
  logic [9:0] disp_addr;
  logic [9:0] clr_cnt;
  colour_t    clr_fill;

  logic       clr_start;
  logic       clr_step;
  logic       err_drop;

  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  wr_req_t    fifo_head;
  wr_req_t    fifo_in;

  assign active    = (hc < HPIXELS) && (vc < VPIXELS);
  assign disp_addr = 10'((vc / 10'(TILE_PX)) * 10'(TILES_X) + hc / 10'(TILE_PX));
  assign clr_busy  = (state == CLEAR);

  assign fifo_in.addr = wr.wr_addr;
  assign fifo_in.data = wr.wr_data;
  assign wr.wr_ready  = !fifo_full;

  tile_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr.wr_valid),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM port mux and next-state logic: display, then clear, then FIFO head.
  always_comb begin
    next_state = state;
    ram_addr   = 10'd0;
    ram_we     = 1'b0;
    ram_wdata  = BLK;
    fifo_pop   = 1'b0;
    clr_start  = 1'b0;
    clr_step   = 1'b0;
    err_drop   = 1'b0;

    if (active) begin
      ram_addr = disp_addr;
    end else if (state == CLEAR) begin
      ram_addr  = clr_cnt;
      ram_we    = 1'b1;
      ram_wdata = clr_fill;
      clr_step  = 1'b1;
    end else if (!fifo_empty) begin
      // Out-of-range heads still consume their slot so the queue keeps moving.
      fifo_pop = 1'b1;
      if (fifo_head.addr < NUM_TILES) begin
        ram_addr  = fifo_head.addr;
        ram_we    = 1'b1;
        ram_wdata = fifo_head.data;
      end else begin
        err_drop = 1'b1;
      end
    end else begin
      ram_addr = 10'd0;
    end

    case (state)
      IDLE: begin
        if (clr_req) begin
          next_state = CLEAR;
          clr_start  = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      CLEAR: begin
        // A second clr_req here is deliberately ignored.
        if (clr_step && (clr_cnt == LAST_TILE)) begin
          next_state = IDLE;
        end else begin
          next_state = CLEAR;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Clear sweep counter and latched fill colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt  <= 10'd0;
      clr_fill <= BLK;
    end else if (clr_start) begin
      clr_cnt  <= 10'd0;
      clr_fill <= clr_color;
    end else if (clr_step) begin
      clr_cnt <= clr_cnt + 10'd1;
    end
  end

  // Sticky drop flag for out-of-range writer requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (err_drop) begin
      wr_err <= 1'b1;
    end
  end

  // Pixel pipeline: active flag follows the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_d1 <= 1'b0;
      px_color  <= BLK;
    end else begin
      active_d1 <= active;
      px_color  <= active_d1 ? ram_rdata : BLK;
    end
  end

endmodule

// File: tb/tb_tile_fb_arbiter.sv
// Self-checking bench for tile_fb_arbiter: a RAM model, a write scoreboard
// fed by the stimulus and drained by a monitor, plus directed checks.
module tb_tile_fb_arbiter;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       clr_req;
  colour_t    clr_color;
  logic       clr_busy;
  logic       wr_err;
  logic [9:0] ram_addr;
  logic       ram_we;
  colour_t    ram_wdata;
  colour_t    ram_rdata;
  colour_t    px_color;

  tile_fb_arbiter_if wif();

  tile_fb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hc        (hc),
    .vc        (vc),
    .wr        (wif.slave),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .wr_err    (wr_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .px_color  (px_color)
  );

  always #5 clk = ~clk;

  // Tile RAM model with registered read.
  colour_t ram [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int clr_writes = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the next expected {addr,data}.
  always @(negedge clk) begin : mon
    logic [17:0] e;
    if (rst_n === 1'b1 && ram_we === 1'b1) begin
      if (clr_busy) clr_writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0d data 0x%0h required=no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("ram_write", {14'd0, ram_addr, ram_wdata}, {14'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one writer request; expected RAM write queued when accepted.
  task automatic wr_push(input logic [9:0] a, input colour_t d, input bit lands);
    bit ok = 1'b0;
    int n = 0;
    wif.wr_valid = 1'b1;
    wif.wr_addr  = a;
    wif.wr_data  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = wif.wr_ready;
      step();
      n++;
    end
    wif.wr_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wr_accept_timeout actual=not accepted required=accepted addr %0d", a);
    end else if (lands) begin
      exp_q.push_back({a, d});
    end
  endtask

  initial begin
    bit ok;
    int n;
    rst_n = 1'b0; hc = 10'd640; vc = 10'd0;
    clr_req = 1'b0; clr_color = 8'h00;
    wif.wr_valid = 1'b0; wif.wr_addr = 10'd0; wif.wr_data = 8'h00;
    #2;
    chk("rst_px", px_color, 32'h0);
    chk("rst_ready", wif.wr_ready, 32'h1);
    chk("rst_busy", clr_busy, 32'h0);
    chk("rst_err", wr_err, 32'h0);
    chk("rst_we", ram_we, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Display path: tile 174 red, latency 2.
    wr_push(10'd174, 8'hE0, 1'b1);
    repeat (3) step();
    hc = 10'd280; vc = 10'd100;
    #1;
    chk("disp_addr", ram_addr, 32'd174);
    chk("disp_we", ram_we, 32'h0);
    step();
    hc = 10'd640;
    step();
    chk("px_active", px_color, 32'hE0);
    step();
    chk("px_blank", px_color, 32'h00);

    // Write during active line waits for blanking.
    hc = 10'd100; vc = 10'd50;
    wr_push(10'd10, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("we_in_active", ram_we, 32'h0);
      step();
    end
    hc = 10'd640;
    #1;
    chk("blank_we", ram_we, 32'h1);
    chk("blank_addr", ram_addr, 32'd10);
    step();

    // Fill the FIFO in active area; fifth request is held off.
    hc = 10'd100; vc = 10'd60;
    for (int i = 0; i < 4; i++) begin
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 10'(20 + i);
      wif.wr_data  = 8'(8'h10 + i);
      #1;
      chk("ready_not_full", wif.wr_ready, 32'h1);
      exp_q.push_back({10'(20 + i), 8'(8'h10 + i)});
      step();
    end
    wif.wr_addr = 10'd24;
    wif.wr_data = 8'h14;
    #1;
    chk("ready_full", wif.wr_ready, 32'h0);
    repeat (3) begin
      step();
      chk("ready_held", wif.wr_ready, 32'h0);
    end
    hc = 10'd640;
    #1;
    chk("ready_prepop", wif.wr_ready, 32'h0);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = wif.wr_ready;
      step();
      n++;
    end
    wif.wr_valid = 1'b0;
    chk("fifth_accepted", ok, 32'h1);
    if (ok) exp_q.push_back({10'd24, 8'h14});
    repeat (8) step();
    chk("drain_done", exp_q.size(), 32'd0);

    // Full-screen clear with a queued write and a redundant clr_req.
    hc = 10'd0; vc = 10'd480;
    clr_req = 1'b1; clr_color = 8'h03;
    for (int i = 0; i < 768; i++) exp_q.push_back({10'(i), 8'h03});
    clr_writes = 0;
    step();
    clr_req = 1'b0; clr_color = 8'h00;
    chk("clr_busy_set", clr_busy, 32'h1);
    repeat (100) step();
    hc = 10'd0; vc = 10'd0;
    wr_push(10'd5, 8'h5A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("clr_paused", ram_we, 32'h0);
      step();
    end
    hc = 10'd0; vc = 10'd480;
    clr_req = 1'b1; clr_color = 8'hC0;
    step();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 1000) begin
      step();
      n++;
    end
    chk("clr_busy_done", clr_busy, 32'h0);
    repeat (4) step();
    chk("clr_write_count", clr_writes, 32'd768);
    chk("clr_queue_empty", exp_q.size(), 32'd0);
    hc = 10'd100; vc = 10'd0;
    step(); step();
    chk("px_tile5", px_color, 32'h5A);
    hc = 10'd620; vc = 10'd460;
    step(); step();
    chk("px_tile767", px_color, 32'h03);
    hc = 10'd0; vc = 10'd0;
    step(); step();
    chk("px_tile0", px_color, 32'h03);

    // Out-of-range request is dropped and flagged.
    hc = 10'd640; vc = 10'd0;
    wr_push(10'd800, 8'hAA, 1'b0);
    repeat (3) step();
    chk("err_set", wr_err, 32'h1);
    repeat (10) step();
    chk("err_sticky", wr_err, 32'h1);
    chk("err_no_write", exp_q.size(), 32'd0);

    // Asynchronous reset mid-frame with a queued write pending.
    hc = 10'd300; vc = 10'd200;
    wr_push(10'd30, 8'h77, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_px", px_color, 32'h0);
    chk("arst_ready", wif.wr_ready, 32'h1);
    chk("arst_busy", clr_busy, 32'h0);
    chk("arst_err", wr_err, 32'h0);
    step();
    hc = 10'd640;
    rst_n = 1'b1;
    repeat (5) step();
    chk("arst_queue_lost", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
